// File: rtl/axis_param_scheduler.sv
// Shares one parameter calculator across NUM_AXES axes. Each axis is issued in index
// order, held for a fixed latency, and its 5-word result is captured into a per-axis bank.
module axis_param_scheduler #(
  parameter int NUM_AXES     = 4,
  parameter int CALC_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NUM_AXES-1:0][31:0]       steps,
  input  logic [4:0][31:0]                max_params,
  input  logic [3:0][63:0]                max_timing,
  output logic                            calc_reset,
  output logic [4:0][31:0]                calc_params,
  output logic [4:0][31:0]                calc_max_params,
  output logic [3:0][63:0]                calc_max_timing,
  input  logic [4:0][31:0]                calc_new_par,
  output logic [NUM_AXES-1:0][4:0][31:0]  axis_par,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted
);

  localparam int IDX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int CNT_W = (CALC_LATENCY > 1) ? $clog2(CALC_LATENCY + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_AXES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CALC_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, DONE} state_t;

  state_t                       state, next_state;
  logic [NUM_AXES-1:0][31:0]    steps_q;
  logic [IDX_W-1:0]             idx;
  logic [CNT_W-1:0]             cnt;
  logic                         bypass;

  assign calc_reset = ~reset;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE) && !abort;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ISSUE;
      ISSUE:   next_state = (steps_q[idx] != 32'd0) ? WAIT : STORE;
      WAIT:    if (cnt == LAST_CNT) next_state = STORE;
      STORE:   next_state = (idx == LAST_IDX) ? DONE : ISSUE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Abort cancels any active state, including a pending STORE
    if (state != IDLE && abort) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      steps_q         <= '0;
      calc_params     <= '0;
      calc_max_params <= '0;
      calc_max_timing <= '0;
      axis_par        <= '0;
      idx             <= '0;
      cnt             <= '0;
      bypass          <= 1'b0;
      aborted         <= 1'b0;
    end else begin
      aborted <= abort && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            steps_q         <= steps;
            calc_max_params <= max_params;
            calc_max_timing <= max_timing;
            idx             <= '0;
          end
        end
        ISSUE: begin
          calc_params <= {steps_q[idx], 128'd0};
          bypass      <= (steps_q[idx] == 32'd0);
          cnt         <= '0;
        end
        WAIT: begin
          if (cnt != LAST_CNT) cnt <= cnt + 1'b1;
        end
        STORE: begin
          if (!abort) begin
            axis_par[idx] <= bypass ? '0 : calc_new_par;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_param_scheduler.sv
// Bench for axis_param_scheduler with a two-cycle registered calculator stand-in;
// expected banks are queued at start and popped when a sequence finishes or is cancelled.
module tb_axis_param_scheduler;
  localparam int NA  = 4;
  localparam int LAT = 2;

  typedef logic [4:0][31:0]        res_t;
  typedef logic [NA-1:0][31:0]     steps_t;
  typedef logic [NA-1:0][4:0][31:0] bank_t;

  logic clk = 1'b0;
  logic reset, start, abort;
  steps_t steps;
  logic [4:0][31:0] max_params, calc_params, calc_max_params, calc_new_par;
  logic [3:0][63:0] max_timing, calc_max_timing;
  logic calc_reset, busy, done, aborted;
  bank_t axis_par;

  axis_param_scheduler #(.NUM_AXES(NA), .CALC_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .steps(steps),
    .max_params(max_params), .max_timing(max_timing), .calc_reset(calc_reset),
    .calc_params(calc_params), .calc_max_params(calc_max_params),
    .calc_max_timing(calc_max_timing), .calc_new_par(calc_new_par),
    .axis_par(axis_par), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Calculator stand-in: result {N, N, tt, max_params[2], max_params[1]} two cycles after inputs
  res_t s1, s2;
  always_ff @(posedge clk) begin
    if (calc_reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {calc_params[4], calc_params[4], calc_max_timing[0][31:0],
             calc_max_params[2], calc_max_params[1]};
      s2 <= s1;
    end
  end
  assign calc_new_par = s2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  res_t q[$];

  localparam logic [4:0][31:0] MP_STD = {32'd100, 32'd10, 32'd5000, 32'd300, 32'd7};
  localparam logic [3:0][63:0] MT_STD = {64'd11, 64'd22, 64'd33, 64'd2000};

  typedef struct {
    steps_t st;
    bank_t  bank;
    int     done_cyc;
  } vec_t;
  vec_t vecs[5];

  function automatic res_t ex(input logic [31:0] n);
    if (n == 32'd0) return '0;
    return {n, n, 32'd2000, 32'd5000, 32'd300};
  endfunction

  function automatic steps_t mk(input int a0, input int a1, input int a2, input int a3);
    steps_t s;
    s[0] = a0; s[1] = a1; s[2] = a2; s[3] = a3;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input bank_t b);
    for (int i = 0; i < NA; i++) q.push_back(b[i]);
  endtask

  task automatic check_bank(input string nm);
    res_t e;
    for (int i = 0; i < NA; i++) begin
      if (q.size() == 0) begin
        chk($sformatf("%s_ax%0d_queue_empty", nm, i), 1, 0);
      end else begin
        e = q.pop_front();
        chk($sformatf("%s_ax%0d", nm, i), axis_par[i], e);
      end
    end
  endtask

  task automatic accept(input steps_t st);
    @(negedge clk);
    steps = st;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input string nm, input int exp_cyc, input bit pulse_start);
    int guard = 0;
    while (!done && guard < 60) begin
      tick();
      guard++;
    end
    if (!done) begin
      chk({nm, "_done_timeout"}, 0, 1);
    end else begin
      chk({nm, "_done_cycle"}, cyc, exp_cyc);
      chk({nm, "_busy_at_done"}, busy, 1);
      if (pulse_start) start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, "_busy_after_done"}, busy, 0);
      chk({nm, "_done_one_cycle"}, done, 0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; steps = '0;
    max_params = MP_STD; max_timing = MT_STD;

    vecs[0].st = mk(1, 1, 1, 1); vecs[0].done_cyc = 17;
    vecs[1].st = mk(0, 0, 0, 0); vecs[1].done_cyc = 9;
    vecs[2].st = mk(1, 0, 1, 0); vecs[2].done_cyc = 13;
    vecs[3].st = mk(5, 0, 0, 3); vecs[3].done_cyc = 13;
    vecs[4].st = mk(0, 0, 0, 7); vecs[4].done_cyc = 11;
    for (int v = 0; v < 5; v++)
      for (int i = 0; i < NA; i++) vecs[v].bank[i] = ex(vecs[v].st[i]);

    // Reset state
    repeat (3) tick();
    chk("rst_calc_reset", calc_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_calc_params", calc_params, 0);
    chk("rst_bank0", axis_par[0], 0);
    reset = 1'b1;
    tick();
    chk("run_calc_reset", calc_reset, 0);

    // Table-driven full sequences
    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].st);
      push_exp(vecs[v].bank);
      chk($sformatf("vec%0d_busy_c1", v), busy, 1);
      wait_done($sformatf("vec%0d", v), vecs[v].done_cyc, 1'b0);
      chk($sformatf("vec%0d_calc_params", v), calc_params, {vecs[v].st[NA-1], 128'd0});
      check_bank($sformatf("vec%0d", v));
    end

    // Abort in IDLE is ignored
    @(negedge clk); abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_aborted", aborted, 0);
    chk("idle_abort_busy", busy, 0);

    // Prefill banks, then abort during axis 2 WAIT
    accept(mk(3, 3, 3, 3));
    push_exp({ex(3), ex(3), ex(3), ex(3)});
    wait_done("prefill", 17, 1'b0);
    check_bank("prefill");
    accept(mk(1, 1, 1, 1));
    while (cyc < 10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_wait_aborted", aborted, 1);
    chk("abort_wait_done", done, 0);
    chk("abort_wait_busy", busy, 0);
    tick();
    chk("abort_wait_pulse_end", aborted, 0);
    push_exp({ex(3), ex(3), ex(1), ex(1)});
    check_bank("abort_wait");
    accept(mk(1, 1, 1, 1));
    push_exp({ex(1), ex(1), ex(1), ex(1)});
    wait_done("after_abort", 17, 1'b0);
    check_bank("after_abort");

    // Start and abort together in IDLE: start wins; then abort beats axis 0 STORE
    @(negedge clk);
    steps = mk(2, 2, 2, 2); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; cyc = 1;
    chk("start_wins_busy", busy, 1);
    chk("start_wins_aborted", aborted, 0);
    while (cyc < 4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_store_aborted", aborted, 1);
    push_exp({ex(1), ex(1), ex(1), ex(1)});
    check_bank("abort_store");

    // Inputs change and start re-pulses mid-run; start during DONE also ignored
    accept(mk(1, 1, 1, 1));
    while (cyc < 3) tick();
    steps = mk(9, 9, 9, 9);
    max_params = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    max_timing = {64'd1, 64'd2, 64'd3, 64'd4};
    while (cyc < 6) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    push_exp({ex(1), ex(1), ex(1), ex(1)});
    wait_done("restart_ignored", 17, 1'b1);
    check_bank("restart_ignored");
    chk("latched_max_params", calc_max_params, MP_STD);
    max_params = MP_STD; max_timing = MT_STD;

    // Reset during WAIT
    accept(mk(1, 1, 1, 1));
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_calc_reset_now", calc_reset, 1);
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_aborted", aborted, 0);
    chk("midrst_calc_params", calc_params, 0);
    chk("midrst_calc_max_params", calc_max_params, 0);
    chk("midrst_calc_max_timing", calc_max_timing[0], 0);
    for (int i = 0; i < NA; i++) chk($sformatf("midrst_bank%0d", i), axis_par[i], 0);
    reset = 1'b1;
    tick();
    chk("midrst_release_calc_reset", calc_reset, 0);
    chk("midrst_release_busy", busy, 0);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
